// File: rtl/ts4231_pkg.sv
// Shared types and constants for the TS4231 envelope pulse capture path.
// Holds the FSM encoding, default pulse limits and record field widths.
package ts4231_pkg;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_ARM      = 3'd1,
    ST_IDLE     = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_HOLD     = 3'd4
  } state_e;

  localparam int DEF_TS_WIDTH   = 32;
  localparam int DEF_PW_WIDTH   = 16;
  localparam int DEF_MIN_WIDTH  = 10;
  localparam int DEF_MAX_WIDTH  = 60000;
  localparam int CNT_WIDTH      = 8;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/ts4231_sync.sv
// Two-flop synchroniser for the asynchronous E pad, followed by polarity
// normalisation so that env=1 always means light. Resets to "no light".
module ts4231_sync #(
  parameter bit ENV_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic e_in,
  output logic env
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = e_in;
    sync_d = meta_q;
  end

  // Reset the raw-domain flops to the pad level that means "dark".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= ENV_ACTIVE_LOW;
      sync_q <= ENV_ACTIVE_LOW;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign env = sync_q ^ ENV_ACTIVE_LOW;

endmodule

// File: rtl/ts4231_pulse_capture.sv
// Measures light pulses on the TS4231 envelope line: rising-edge timestamp and
// width, delivered one record per pulse through a single-entry valid/ready buffer.
module ts4231_pulse_capture
  import ts4231_pkg::*;
#(
  parameter int TS_WIDTH       = DEF_TS_WIDTH,
  parameter int PW_WIDTH       = DEF_PW_WIDTH,
  parameter int MIN_WIDTH      = DEF_MIN_WIDTH,
  parameter int MAX_WIDTH      = DEF_MAX_WIDTH,
  parameter bit ENV_ACTIVE_LOW = 1'b0
) (
  input  logic                 clk_96MHz,
  input  logic                 rst_n,
  input  logic                 configured,
  input  logic                 e_in,
  output logic                 pulse_valid,
  input  logic                 pulse_ready,
  output logic [TS_WIDTH-1:0]  pulse_timestamp,
  output logic [PW_WIDTH-1:0]  pulse_width,
  output logic                 pulse_timeout,
  output logic [CNT_WIDTH-1:0] dropped_count,
  output logic [CNT_WIDTH-1:0] glitch_count
);

  // Handshake: a record transfers on any clock edge where pulse_valid and
  // pulse_ready are both high; while pulse_valid is high the record fields
  // hold steady, and pulse_valid never drops without a transfer.

  localparam logic [PW_WIDTH-1:0] MIN_W     = PW_WIDTH'(MIN_WIDTH);
  localparam logic [PW_WIDTH-1:0] MAX_W     = PW_WIDTH'(MAX_WIDTH);
  localparam logic [PW_WIDTH-1:0] MAX_W_M1  = PW_WIDTH'(MAX_WIDTH - 1);

  logic env;

  ts4231_sync #(
    .ENV_ACTIVE_LOW(ENV_ACTIVE_LOW)
  ) u_sync (
    .clk   (clk_96MHz),
    .rst_n (rst_n),
    .e_in  (e_in),
    .env   (env)
  );

  state_e                state_q, state_d;
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [TS_WIDTH-1:0]   start_ts_q, start_ts_d;
  logic [PW_WIDTH-1:0]   width_q, width_d;
  logic [CNT_WIDTH-1:0]  glitch_q, glitch_d;
  logic [CNT_WIDTH-1:0]  dropped_q, dropped_d;
  logic                  valid_q, valid_d;
  logic [TS_WIDTH-1:0]   rec_ts_q, rec_ts_d;
  logic [PW_WIDTH-1:0]   rec_width_q, rec_width_d;
  logic                  rec_timeout_q, rec_timeout_d;

  logic                  emit;
  logic [PW_WIDTH-1:0]   emit_width;
  logic                  emit_timeout;

  // Free-running timebase, independent of the configured flag.
  always_comb begin
    ts_d = ts_q + TS_WIDTH'(1);
  end

  // Pulse measurement FSM.
  always_comb begin
    state_d      = state_q;
    start_ts_d   = start_ts_q;
    width_d      = width_q;
    glitch_d     = glitch_q;
    emit         = 1'b0;
    emit_width   = width_q;
    emit_timeout = 1'b0;

    if (!configured) begin
      // Any partially measured pulse is silently abandoned.
      state_d = ST_DISABLED;
    end else begin
      unique case (state_q)
        ST_DISABLED: begin
          state_d = env ? ST_ARM : ST_IDLE;
        end
        ST_ARM: begin
          if (!env) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          // IDLE is only reached with env low, so env high here is a rising edge.
          if (env) begin
            start_ts_d = ts_q;
            width_d    = PW_WIDTH'(1);
            state_d    = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (env) begin
            width_d = width_q + PW_WIDTH'(1);
            if (width_q == MAX_W_M1) begin
              emit         = 1'b1;
              emit_width   = MAX_W;
              emit_timeout = 1'b1;
              state_d      = ST_HOLD;
            end
          end else begin
            state_d = ST_IDLE;
            if (width_q < MIN_W) begin
              glitch_d = sat_inc(glitch_q);
            end else begin
              emit = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (!env) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_DISABLED;
        end
      endcase
    end
  end

  // Single-entry output buffer; a new record may replace one being accepted.
  always_comb begin
    valid_d       = valid_q;
    rec_ts_d      = rec_ts_q;
    rec_width_d   = rec_width_q;
    rec_timeout_d = rec_timeout_q;
    dropped_d     = dropped_q;

    if (emit) begin
      if (!valid_q || pulse_ready) begin
        valid_d       = 1'b1;
        rec_ts_d      = start_ts_q;
        rec_width_d   = emit_width;
        rec_timeout_d = emit_timeout;
      end else begin
        dropped_d = sat_inc(dropped_q);
      end
    end else if (valid_q && pulse_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_96MHz) begin
    if (!rst_n) begin
      state_q       <= ST_DISABLED;
      ts_q          <= '0;
      start_ts_q    <= '0;
      width_q       <= '0;
      glitch_q      <= '0;
      dropped_q     <= '0;
      valid_q       <= 1'b0;
      rec_ts_q      <= '0;
      rec_width_q   <= '0;
      rec_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ts_q          <= ts_d;
      start_ts_q    <= start_ts_d;
      width_q       <= width_d;
      glitch_q      <= glitch_d;
      dropped_q     <= dropped_d;
      valid_q       <= valid_d;
      rec_ts_q      <= rec_ts_d;
      rec_width_q   <= rec_width_d;
      rec_timeout_q <= rec_timeout_d;
    end
  end

  assign pulse_valid     = valid_q;
  assign pulse_timestamp = rec_ts_q;
  assign pulse_width     = rec_width_q;
  assign pulse_timeout   = rec_timeout_q;
  assign dropped_count   = dropped_q;
  assign glitch_count    = glitch_q;

endmodule

// File: doc/ts4231_pulse_capture.md
# ts4231_pulse_capture

- Receive side of the TS4231 envelope (E) line once the sensor is configured.
- Synchronises E into the 96 MHz domain and filters glitches.
- Measures each light pulse: rising-edge timestamp and width in clock cycles.
- Presents one record per pulse on a valid/ready interface to the lighthouse decoding logic.
- Sits beside the sensor configurator; capture is gated by its `configured` flag.

## Interface
Parameters:
- TS_WIDTH, 32: width of the free-running timestamp counter and `pulse_timestamp`.
- PW_WIDTH, 16: width of `pulse_width`.
- MIN_WIDTH, 10: shortest accepted pulse, in cycles. Shorter pulses are glitches.
- MAX_WIDTH, 16'd60000: width at which a pulse is reported as timed out.
- ENV_ACTIVE_LOW, 0: 1 means E low indicates light.

Ports:
- clk_96MHz  in  1  system clock. Only clock.
- rst_n  in  1  synchronous, active-low reset.
- configured  in  1  sensor configured; capture enable.
- e_in  in  1  raw E pad input, asynchronous.
- pulse_valid  out  1  record available.
- pulse_ready  in  1  consumer accepts the record.
- pulse_timestamp  out  TS_WIDTH  counter value at the detected rising edge.
- pulse_width  out  PW_WIDTH  active cycles of the synchronised envelope.
- pulse_timeout  out  1  pulse reached MAX_WIDTH.
- dropped_count  out  8  saturating count of records lost to backpressure.
- glitch_count  out  8  saturating count of pulses shorter than MIN_WIDTH.

## Operation
- `e_in` passes through a 2-FF synchroniser, then is XORed with ENV_ACTIVE_LOW, giving `env`.
- A timestamp counter increments every cycle from 0 after reset and wraps modulo 2^TS_WIDTH. It does not depend on `configured`.

FSM states:
- DISABLED: held while `configured`=0.
  - `configured` 0→1 with `env`=1: go to ARM.
  - `configured` 0→1 with `env`=0: go to IDLE.
- ARM: wait for `env`=0, then go to IDLE. A pulse already in progress is never measured.
- IDLE: on `env` 0→1, latch the timestamp, set width=1, go to ACTIVE.
- ACTIVE: width increments each cycle `env`=1.
  - On `env`=0 with width<MIN_WIDTH: increment glitch_count, no record.
  - On `env`=0 with width≥MIN_WIDTH: emit a record with timeout=0.
  - Either way, return to IDLE.
  - If width reaches MAX_WIDTH: emit a record with width=MAX_WIDTH and timeout=1, go to HOLD.
- HOLD: wait for `env`=0, then go to IDLE. No further record is emitted for this pulse.
- `configured`=0 in any state: go to DISABLED next cycle. A pulse in progress is discarded without a record or glitch count.

Output buffer:
- Single entry. Emit with buffer empty, or emit in the same cycle as `pulse_valid`&&`pulse_ready`: the new record is loaded and `pulse_valid` stays 1.
- Emit while buffer is full and not being accepted: the new record is dropped, dropped_count increments, and the buffered record is unchanged.
- Record fields are stable while `pulse_valid`=1.
- Both counters saturate at 255. They clear only on reset.

## Timing
- Reset values: `pulse_valid`=0, `pulse_timestamp`=0, `pulse_width`=0, `pulse_timeout`=0, dropped_count=0, glitch_count=0, timestamp counter=0, FSM=DISABLED.
- Synchroniser latency is 2 cycles. The latched timestamp is the counter value in the cycle `env` is first seen high. There is no compensation; the fixed 2-cycle offset is the consumer's concern.
- Completed pulse: `pulse_valid` rises 1 cycle after the first `env`=0 cycle.
- Timeout: `pulse_valid` rises 1 cycle after width reaches MAX_WIDTH.
- Width counts synchronised cycles, so an E pulse of N clock cycles reports width N.
- Minimum back-to-back gap is 1 inactive cycle; IDLE accepts a rising edge immediately.
- Timestamp wrap inside a pulse needs no handling, because width comes from its own counter.

## Structure
- Package `ts4231_pkg` holds:
  - FSM state encoding: DISABLED, ARM, IDLE, ACTIVE, HOLD.
  - Default MIN_WIDTH and MAX_WIDTH constants.
  - Record field widths.
- Sub-module `ts4231_sync`: 2-FF synchroniser with polarity normalisation, reset value "inactive".
- The FSM, counters and output buffer live in the top module.

## Test plan
- `configured`=1, E high for 100 cycles starting at counter 500, `pulse_ready`=1 → one record: timestamp 502, width 100, timeout 0.
- E pulses of 9 and 10 cycles → 9-cycle pulse: glitch_count=1, no record. 10-cycle pulse: one record with width 10.
- E held high for 70000 cycles → one record with width 60000 and timeout 1. `pulse_valid` stays 0 after acceptance until E falls and rises again.
- `pulse_ready`=0, three 50-cycle pulses → first record retained, dropped_count=2. Then `pulse_ready`=1 in the same cycle a fourth pulse completes → fourth record loaded, no drop.
- `configured` rises while E is high, and `configured` falls mid-pulse → no record or glitch in either case. The next full pulse after E returns low is captured normally.
- `rst_n`=0 for 1 cycle mid-ACTIVE with `pulse_valid`=1 → all outputs return to reset values on the next cycle and FSM=DISABLED.
